// File: rtl/axi_mem_arbiter_if.sv
// AXI4 bundle shared by the two master ports and the slave port of axi_mem_arbiter.
// "master" is the view from the side that issues requests; "slave" is the view from the side that answers them.
interface axi_mem_arbiter_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter with independent round-robin read and write paths,
// one outstanding transaction per direction; the slave ID MSB tags the owning master.
module axi_mem_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic               clk,
  input logic               rst,
  axi_mem_arbiter_if.slave  m0,
  axi_mem_arbiter_if.slave  m1,
  axi_mem_arbiter_if.master s
);
  typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wstate_t;
  typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;
  logic    wgnt, wgnt_next, wlast_gnt, wlast_next;
  logic    rgnt, rgnt_next, rlast_gnt, rlast_next;

  logic                    aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel, btag;
  logic                    ar_valid_sel, r_ready_sel, rtag;
  logic [ADDR_WIDTH-1:0]   awaddr_sel, araddr_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic [DATA_WIDTH/8-1:0] wstrb_sel;

  // last_gnt resets to 1 so that M0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate    <= WIDLE;
      wgnt      <= 1'b0;
      wlast_gnt <= 1'b1;
    end else begin
      wstate    <= wnext;
      wgnt      <= wgnt_next;
      wlast_gnt <= wlast_next;
    end
  end

  always_comb begin
    wnext        = wstate;
    wgnt_next    = wgnt;
    wlast_next   = wlast_gnt;
    aw_valid_sel = wgnt ? m1.awvalid : m0.awvalid;
    awaddr_sel   = wgnt ? m1.awaddr  : m0.awaddr;
    w_valid_sel  = wgnt ? m1.wvalid  : m0.wvalid;
    w_last_sel   = wgnt ? m1.wlast   : m0.wlast;
    wdata_sel    = wgnt ? m1.wdata   : m0.wdata;
    wstrb_sel    = wgnt ? m1.wstrb   : m0.wstrb;
    btag         = s.bid[ID_WIDTH];
    b_ready_sel  = btag ? m1.bready : m0.bready;

    s.awid    = '0;
    s.awaddr  = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = 1'b0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    m0.awready = 1'b0;
    m1.awready = 1'b0;
    m0.wready  = 1'b0;
    m1.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m1.bvalid  = 1'b0;
    m0.bid     = s.bid[ID_WIDTH-1:0];
    m1.bid     = s.bid[ID_WIDTH-1:0];
    m0.bresp   = s.bresp;
    m1.bresp   = s.bresp;

    unique case (wstate)
      WIDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          wgnt_next = (m0.awvalid && m1.awvalid) ? ~wlast_gnt : m1.awvalid;
          wnext     = WADDR;
        end
      end
      WADDR: begin
        s.awid     = {wgnt, wgnt ? m1.awid : m0.awid};
        s.awaddr   = awaddr_sel;
        s.awlen    = wgnt ? m1.awlen   : m0.awlen;
        s.awsize   = wgnt ? m1.awsize  : m0.awsize;
        s.awburst  = wgnt ? m1.awburst : m0.awburst;
        s.awvalid  = aw_valid_sel;
        m0.awready = ~wgnt & s.awready;
        m1.awready = wgnt & s.awready;
        if (aw_valid_sel && s.awready) wnext = WDATA;
      end
      WDATA: begin
        s.wdata   = wdata_sel;
        s.wstrb   = wstrb_sel;
        s.wlast   = w_last_sel;
        s.wvalid  = w_valid_sel;
        m0.wready = ~wgnt & s.wready;
        m1.wready = wgnt & s.wready;
        if (w_valid_sel && s.wready && w_last_sel) wnext = WRESP;
      end
      WRESP: begin
        s.bready  = b_ready_sel;
        m0.bvalid = s.bvalid & ~btag;
        m1.bvalid = s.bvalid & btag;
        if (s.bvalid && b_ready_sel) begin
          wlast_next = wgnt;
          wnext      = WIDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate    <= RIDLE;
      rgnt      <= 1'b0;
      rlast_gnt <= 1'b1;
    end else begin
      rstate    <= rnext;
      rgnt      <= rgnt_next;
      rlast_gnt <= rlast_next;
    end
  end

  always_comb begin
    rnext        = rstate;
    rgnt_next    = rgnt;
    rlast_next   = rlast_gnt;
    ar_valid_sel = rgnt ? m1.arvalid : m0.arvalid;
    araddr_sel   = rgnt ? m1.araddr  : m0.araddr;
    rtag         = s.rid[ID_WIDTH];
    r_ready_sel  = rtag ? m1.rready : m0.rready;

    s.arid    = '0;
    s.araddr  = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    m0.rid     = s.rid[ID_WIDTH-1:0];
    m1.rid     = s.rid[ID_WIDTH-1:0];
    m0.rdata   = s.rdata;
    m1.rdata   = s.rdata;
    m0.rresp   = s.rresp;
    m1.rresp   = s.rresp;
    m0.rlast   = s.rlast;
    m1.rlast   = s.rlast;

    unique case (rstate)
      RIDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          rgnt_next = (m0.arvalid && m1.arvalid) ? ~rlast_gnt : m1.arvalid;
          rnext     = RADDR;
        end
      end
      RADDR: begin
        s.arid     = {rgnt, rgnt ? m1.arid : m0.arid};
        s.araddr   = araddr_sel;
        s.arlen    = rgnt ? m1.arlen   : m0.arlen;
        s.arsize   = rgnt ? m1.arsize  : m0.arsize;
        s.arburst  = rgnt ? m1.arburst : m0.arburst;
        s.arvalid  = ar_valid_sel;
        m0.arready = ~rgnt & s.arready;
        m1.arready = rgnt & s.arready;
        if (ar_valid_sel && s.arready) rnext = RDATA;
      end
      RDATA: begin
        s.rready  = r_ready_sel;
        m0.rvalid = s.rvalid & ~rtag;
        m1.rvalid = s.rvalid & rtag;
        if (s.rvalid && r_ready_sel && s.rlast) begin
          rlast_next = rgnt;
          rnext      = RIDLE;
        end
      end
      default: rnext = RIDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: directed master stimulus, a behavioural AXI memory slave,
// and negedge monitors that pop expected beats whenever a handshake is presented.
`timescale 1ns/1ps
module tb_axi_mem_arbiter;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_arbiter_if #(.ID_WIDTH(IW),     .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
  axi_mem_arbiter_if #(.ID_WIDTH(IW),     .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();
  axi_mem_arbiter_if #(.ID_WIDTH(IW + 1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s ();

  axi_mem_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s)
  );

  typedef struct { logic [3:0] id; logic [63:0] data; logic last; } rexp_t;
  typedef struct { logic [4:0] id; logic [31:0] addr; logic [7:0] len; } aexp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } wexp_t;

  rexp_t      exp_r0[$], exp_r1[$];
  logic [3:0] exp_b0[$], exp_b1[$];
  aexp_t      exp_ar[$], exp_aw[$];
  wexp_t      exp_w[$];

  int checks = 0;
  int failures = 0;
  int r0_beats = 0;
  int w_beats = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected handshake required=none", name);
  endtask

  function automatic logic [63:0] pat(input int unsigned i);
    return {32'hC0DE_0000 | 32'(i), 32'h1234_0000 | 32'(i)};
  endfunction

  // ---------------- behavioural memory slave ----------------
  logic [63:0] mem [256];
  logic [1:0]  sw_st;
  logic [4:0]  sw_id;
  logic [7:0]  sw_idx;
  logic        sr_st;
  logic [7:0]  sr_idx, sr_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      sw_st <= 2'd0; sw_id <= '0; sw_idx <= '0;
      s.awready <= 1'b0; s.wready <= 1'b0;
      s.bvalid <= 1'b0; s.bid <= '0; s.bresp <= '0;
    end else begin
      case (sw_st)
        2'd0: begin
          s.awready <= 1'b1;
          if (s.awvalid && s.awready) begin
            sw_id <= s.awid; sw_idx <= s.awaddr[10:3];
            s.awready <= 1'b0; s.wready <= 1'b1; sw_st <= 2'd1;
          end
        end
        2'd1: begin
          if (s.wvalid && s.wready) begin
            for (int b = 0; b < 8; b++)
              if (s.wstrb[b]) mem[sw_idx][8*b +: 8] <= s.wdata[8*b +: 8];
            sw_idx <= sw_idx + 8'd1;
            if (s.wlast) begin
              s.wready <= 1'b0; s.bvalid <= 1'b1; s.bid <= sw_id; sw_st <= 2'd2;
            end
          end
        end
        default: begin
          if (s.bvalid && s.bready) begin
            s.bvalid <= 1'b0; s.bid <= '0; sw_st <= 2'd0;
          end
        end
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_st <= 1'b0; sr_idx <= '0; sr_cnt <= '0;
      s.arready <= 1'b0; s.rvalid <= 1'b0; s.rid <= '0;
      s.rdata <= '0; s.rresp <= '0; s.rlast <= 1'b0;
    end else if (!sr_st) begin
      s.arready <= 1'b1;
      if (s.arvalid && s.arready) begin
        s.arready <= 1'b0; s.rvalid <= 1'b1; s.rid <= s.arid;
        s.rdata <= mem[s.araddr[10:3]]; s.rlast <= (s.arlen == 8'd0);
        sr_idx <= s.araddr[10:3] + 8'd1; sr_cnt <= s.arlen; sr_st <= 1'b1;
      end
    end else if (s.rvalid && s.rready) begin
      if (s.rlast) begin
        s.rvalid <= 1'b0; s.rlast <= 1'b0; s.rid <= '0; s.rdata <= '0; sr_st <= 1'b0;
      end else begin
        s.rdata <= mem[sr_idx]; sr_idx <= sr_idx + 8'd1;
        s.rlast <= (sr_cnt == 8'd1); sr_cnt <= sr_cnt - 8'd1;
      end
    end
  end

  // ---------------- monitors ----------------
  rexp_t      er0, er1;
  aexp_t      ear, eaw;
  wexp_t      ew;
  logic [3:0] eb;
  logic       stalled_prev = 1'b0;
  logic [63:0] held = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m0.rvalid && m0.rready) begin
        r0_beats++;
        if (exp_r0.size() == 0) unexp("m0_r");
        else begin
          er0 = exp_r0.pop_front();
          chk("m0_r", 128'({m0.rid, m0.rdata, m0.rresp, m0.rlast}), 128'({er0.id, er0.data, 2'b00, er0.last}));
        end
      end
      if (m1.rvalid && m1.rready) begin
        if (exp_r1.size() == 0) unexp("m1_r");
        else begin
          er1 = exp_r1.pop_front();
          chk("m1_r", 128'({m1.rid, m1.rdata, m1.rresp, m1.rlast}), 128'({er1.id, er1.data, 2'b00, er1.last}));
        end
      end
      if (m0.bvalid && m0.bready) begin
        if (exp_b0.size() == 0) unexp("m0_b");
        else begin eb = exp_b0.pop_front(); chk("m0_b", 128'({m0.bid, m0.bresp}), 128'({eb, 2'b00})); end
      end
      if (m1.bvalid && m1.bready) begin
        if (exp_b1.size() == 0) unexp("m1_b");
        else begin eb = exp_b1.pop_front(); chk("m1_b", 128'({m1.bid, m1.bresp}), 128'({eb, 2'b00})); end
      end
      if (s.arvalid && s.arready) begin
        if (exp_ar.size() == 0) unexp("s_ar");
        else begin
          ear = exp_ar.pop_front();
          chk("s_ar", 128'({s.arid, s.araddr, s.arlen}), 128'({ear.id, ear.addr, ear.len}));
        end
      end
      if (s.awvalid && s.awready) begin
        if (exp_aw.size() == 0) unexp("s_aw");
        else begin
          eaw = exp_aw.pop_front();
          chk("s_aw", 128'({s.awid, s.awaddr, s.awlen}), 128'({eaw.id, eaw.addr, eaw.len}));
        end
      end
      if (s.wvalid && s.wready) begin
        w_beats++;
        if (exp_w.size() == 0) unexp("s_w");
        else begin
          ew = exp_w.pop_front();
          chk("s_w", 128'({s.wdata, s.wstrb, s.wlast}), 128'({ew.data, ew.strb, ew.last}));
        end
      end
      if (m0.rvalid && !m0.rready) chk("bp_s_rready", 128'(s.rready), 128'(0));
      if (stalled_prev && m0.rvalid) chk("bp_hold", 128'(m0.rdata), 128'(held));
      stalled_prev <= m0.rvalid && !m0.rready;
      held <= m0.rdata;
    end else begin
      stalled_prev <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic zero_masters();
    m0.awid = '0; m0.awaddr = '0; m0.awlen = '0; m0.awsize = '0; m0.awburst = '0; m0.awvalid = 1'b0;
    m0.wdata = '0; m0.wstrb = '0; m0.wlast = 1'b0; m0.wvalid = 1'b0; m0.bready = 1'b1;
    m0.arid = '0; m0.araddr = '0; m0.arlen = '0; m0.arsize = '0; m0.arburst = '0; m0.arvalid = 1'b0;
    m0.rready = 1'b1;
    m1.awid = '0; m1.awaddr = '0; m1.awlen = '0; m1.awsize = '0; m1.awburst = '0; m1.awvalid = 1'b0;
    m1.wdata = '0; m1.wstrb = '0; m1.wlast = 1'b0; m1.wvalid = 1'b0; m1.bready = 1'b1;
    m1.arid = '0; m1.araddr = '0; m1.arlen = '0; m1.arsize = '0; m1.arburst = '0; m1.arvalid = 1'b0;
    m1.rready = 1'b1;
  endtask

  task automatic push_r(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    rexp_t e;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      e.id = id; e.data = pat(32'(addr[10:3]) + i); e.last = (i == 32'(len));
      if (m == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
    end
  endtask

  task automatic push_a(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len, input bit wr);
    aexp_t e;
    e.id = id; e.addr = addr; e.len = len;
    if (wr) exp_aw.push_back(e); else exp_ar.push_back(e);
  endtask

  task automatic issue_ar(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    logic ok;
    ok = 1'b0;
    if (m == 0) begin m0.arid = id; m0.araddr = addr; m0.arlen = len; m0.arsize = 3'd3; m0.arburst = 2'd1; m0.arvalid = 1'b1; end
    else        begin m1.arid = id; m1.araddr = addr; m1.arlen = len; m1.arsize = 3'd3; m1.arburst = 2'd1; m1.arvalid = 1'b1; end
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = (m == 0) ? m0.arready : m1.arready;
    end
    if (!ok) chk("ar_timeout", 128'(ok), 128'(1));
    @(posedge clk); #1;
    if (m == 0) m0.arvalid = 1'b0; else m1.arvalid = 1'b0;
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [63:0] base, input logic [7:0] strb);
    logic  ok;
    wexp_t e;
    push_a({m[0], id}, addr, len, 1'b1);
    if (m == 0) exp_b0.push_back(id); else exp_b1.push_back(id);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      e.data = base + 64'(i); e.strb = strb; e.last = (i == 32'(len));
      exp_w.push_back(e);
    end
    ok = 1'b0;
    if (m == 0) begin m0.awid = id; m0.awaddr = addr; m0.awlen = len; m0.awsize = 3'd3; m0.awburst = 2'd1; m0.awvalid = 1'b1; end
    else        begin m1.awid = id; m1.awaddr = addr; m1.awlen = len; m1.awsize = 3'd3; m1.awburst = 2'd1; m1.awvalid = 1'b1; end
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = (m == 0) ? m0.awready : m1.awready;
    end
    if (!ok) chk("aw_timeout", 128'(ok), 128'(1));
    @(posedge clk); #1;
    if (m == 0) m0.awvalid = 1'b0; else m1.awvalid = 1'b0;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      if (m == 0) begin m0.wdata = base + 64'(i); m0.wstrb = strb; m0.wlast = (i == 32'(len)); m0.wvalid = 1'b1; end
      else        begin m1.wdata = base + 64'(i); m1.wstrb = strb; m1.wlast = (i == 32'(len)); m1.wvalid = 1'b1; end
      ok = 1'b0;
      for (int c = 0; c < 500 && !ok; c++) begin
        @(negedge clk);
        ok = (m == 0) ? m0.wready : m1.wready;
      end
      if (!ok) chk("w_timeout", 128'(ok), 128'(1));
      @(posedge clk); #1;
    end
    if (m == 0) begin m0.wvalid = 1'b0; m0.wlast = 1'b0; end
    else        begin m1.wvalid = 1'b0; m1.wlast = 1'b0; end
  endtask

  task automatic drain(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk);
      ok = (exp_r0.size() == 0) && (exp_r1.size() == 0) && (exp_b0.size() == 0) && (exp_b1.size() == 0) &&
           (exp_ar.size() == 0) && (exp_aw.size() == 0) && (exp_w.size() == 0);
    end
    chk(name, 128'(ok), 128'(1));
    #1;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ctl"}, 128'({m0.awready, m0.wready, m0.bvalid, m0.arready, m0.rvalid,
                              m1.awready, m1.wready, m1.bvalid, m1.arready, m1.rvalid,
                              s.awvalid, s.wvalid, s.bready, s.arvalid, s.rready}), 128'(0));
    chk({name, "_pay"}, 128'({s.awid, s.awaddr, s.arid, s.araddr, s.wdata[31:0], s.wstrb}), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int start;
    zero_masters();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // simultaneous reads from reset: M0 first
    push_a(5'h01, 32'h000, 8'd1, 1'b0);
    push_a(5'h15, 32'h180, 8'd2, 1'b0);
    push_r(0, 32'h000, 8'd1, 4'd1);
    push_r(1, 32'h180, 8'd2, 4'd5);
    fork
      issue_ar(0, 32'h000, 8'd1, 4'd1);
      issue_ar(1, 32'h180, 8'd2, 4'd5);
    join
    drain("pair1_drain");

    // single M0 read with grant-latency check
    push_a(5'h02, 32'h100, 8'd3, 1'b0);
    push_r(0, 32'h100, 8'd3, 4'd2);
    m0.arid = 4'd2; m0.araddr = 32'h100; m0.arlen = 8'd3; m0.arsize = 3'd3; m0.arburst = 2'd1; m0.arvalid = 1'b1;
    @(negedge clk);
    chk("ar_lat_idle", 128'(s.arvalid), 128'(0));
    @(negedge clk);
    chk("ar_lat_addr", 128'({s.arvalid, s.arid, m0.arready, m1.arready}), 128'({1'b1, 5'h02, 1'b1, 1'b0}));
    @(posedge clk); #1;
    m0.arvalid = 1'b0;
    drain("single_rd_drain");

    // second simultaneous pair: M1 wins after M0 was last served
    push_a(5'h17, 32'h1C0, 8'd1, 1'b0);
    push_a(5'h03, 32'h020, 8'd0, 1'b0);
    push_r(1, 32'h1C0, 8'd1, 4'd7);
    push_r(0, 32'h020, 8'd0, 4'd3);
    fork
      issue_ar(0, 32'h020, 8'd0, 4'd3);
      issue_ar(1, 32'h1C0, 8'd1, 4'd7);
    join
    drain("pair2_drain");

    // single M1 write with partial strobe, then read back
    do_write(1, 32'h40, 8'd0, 4'hA, 64'hDEADBEEF_CAFEF00D, 8'h0F);
    drain("single_wr_drain");
    push_a(5'h19, 32'h40, 8'd0, 1'b0);
    exp_r1.push_back('{id: 4'd9, data: 64'hC0DE0008_CAFEF00D, last: 1'b1});
    issue_ar(1, 32'h40, 8'd0, 4'd9);
    drain("readback_drain");

    // concurrent M0 read and M1 write
    push_a(5'h04, 32'h200, 8'd7, 1'b0);
    push_r(0, 32'h200, 8'd7, 4'd4);
    fork
      issue_ar(0, 32'h200, 8'd7, 4'd4);
      do_write(1, 32'h80, 8'd1, 4'h3, 64'h1111_2222_3333_4440, 8'hFF);
    join
    drain("concurrent_drain");

    // backpressure on m0_rready mid-burst
    push_a(5'h01, 32'h300, 8'd3, 1'b0);
    push_r(0, 32'h300, 8'd3, 4'd1);
    start = r0_beats;
    fork
      issue_ar(0, 32'h300, 8'd3, 4'd1);
    join_none
    for (int c = 0; c < 200 && r0_beats == start; c++) @(posedge clk);
    #1 m0.rready = 1'b0;
    repeat (5) @(posedge clk);
    #1 m0.rready = 1'b1;
    drain("bp_drain");

    // reset during the second W beat of a four-beat M1 write
    start = w_beats;
    fork
      do_write(1, 32'h500, 8'd3, 4'h4, 64'hAAAA_0000_0000_0000, 8'hFF);
    join_none
    for (int c = 0; c < 200 && w_beats == start; c++) @(posedge clk);
    #2 rst = 1'b1;
    disable fork;
    #1 check_idle("rst_mid");
    zero_masters();
    exp_aw.delete(); exp_w.delete(); exp_b0.delete(); exp_b1.delete();
    exp_ar.delete(); exp_r0.delete(); exp_r1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_write(1, 32'h500, 8'd3, 4'h6, 64'h5555_0000_0000_0010, 8'hFF);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-master to one-slave AXI4 arbiter that shares the on-chip memory wrapper between the instruction-fetch port (M0) and the load/store port (M1). Read and write paths are arbitrated independently, each with round-robin grant and one outstanding transaction per direction. Slave IDs are widened by one bit to tag the owning master, so responses are routed by ID. The block sits directly in front of the AXI memory wrapper, whose ID_WIDTH is set to this block's ID_WIDTH+1.

## Interface
- ID_WIDTH, default 4: master ID width. Slave ID width is ID_WIDTH+1.
- ADDR_WIDTH, default 32: address width.
- DATA_WIDTH, default 64: data width. Strobe width is DATA_WIDTH/8.

Ports, with mN meaning m0 and m1 (identical port sets):
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous reset, active-high
- mN_aw{id,addr,len[8],size[3],burst[2],valid}  in; mN_awready  out: write address channel
- mN_w{data,strb,last,valid}  in; mN_wready  out: write data channel
- mN_b{id,resp[2],valid}  out; mN_bready  in: write response channel
- mN_ar{id,addr,len[8],size[3],burst[2],valid}  in; mN_arready  out: read address channel
- mN_r{id,data,resp[2],last,valid}  out; mN_rready  in: read data channel
- s_aw{id[ID_WIDTH+1],addr,len,size,burst,valid}  out; s_awready  in: slave write address channel
- s_w{data,strb,last,valid}  out; s_wready  in: slave write data channel
- s_b{id,resp,valid}  in; s_bready  out: slave write response channel
- s_ar{id,addr,len,size,burst,valid}  out; s_arready  in: slave read address channel
- s_r{id,data,resp,last,valid}  in; s_rready  out: slave read data channel

## Operation
- **Write FSM.** States: WIDLE, WADDR, WDATA, WRESP.
  - WIDLE: if any mN_awvalid, grant one master and register wgnt.
    - Both valid: grant the master that was not granted last (wlast_gnt).
    - Then go to WADDR.
  - WADDR: s_aw* = granted master's aw*, with s_awid = {wgnt, mN_awid}. mN_awready = s_awready for the granted master only. On handshake go to WDATA.
  - WDATA: s_w* = granted master's w*; granted mN_wready = s_wready. On a handshake with wlast=1 go to WRESP.
  - WRESP: s_bready = mN_bready of master s_bid[ID_WIDTH]. mN_bvalid = s_bvalid for that master only. mN_bid = s_bid[ID_WIDTH-1:0].
    - On handshake: update wlast_gnt = wgnt, go to WIDLE.
- **Read FSM.** States: RIDLE, RADDR, RDATA.
  - Arbitration is the same as the write FSM, using rgnt and rlast_gnt.
  - RADDR forwards ar* with s_arid = {rgnt, mN_arid}.
  - RDATA routes r* by s_rid[ID_WIDTH]. Leave on a handshake with rlast=1, then update rlast_gnt.
- **Independence.** Read and write FSMs are fully independent. M0 may read while M1 writes.
- **Non-granted masters.** awready, wready and arready are held 0. Their bvalid and rvalid are 0.
- **Payload muxing.**
  - s_ address/data payloads are 0 when their FSM is idle.
  - Response payloads (data, resp, id, last) are broadcast to both masters; only valid is gated.
- **Strobes.** W beats carry wstrb unchanged.
- **Ordering.** Early W beats from a master waiting in WIDLE/WADDR are not accepted.

## Timing
- **Reset values.** All s_*valid, s_bready, s_rready, mN_*ready and mN_*valid are 0. Payload outputs are 0. FSMs are in WIDLE/RIDLE. wlast_gnt = rlast_gnt = 1, so M0 wins the first contention.
- **Arbitration latency.** The grant is registered in IDLE. s_awvalid/s_arvalid rise 1 cycle after mN_*valid is first seen.
- **Address phase.** Combinational pass-through, no added latency.
- **Data and response phases.** Combinational pass-through, no added latency.
- **Back-to-back transactions.** Minimum 1 idle cycle between transactions in the same direction (the IDLE state).
- **Backpressure.** Backpressure propagates combinationally in both directions. An AXI valid, once raised, is never dropped by the arbiter before its handshake.
- **Late arrival.** A master raising valid while the other is in any non-IDLE state waits until return to IDLE, then is granted.
- **Reset mid-burst.** The reset is taken immediately. Both FSMs return to IDLE, the burst is abandoned, and masters and slave are reset by the same rst.
- **Unmatched responses.** A response whose tag master is not the granted master does not occur (one outstanding per direction) and is not checked.

## Test plan
- **Single read.** M0 AR addr 0x100, len=3, id=2 → s_arid=0x02 one cycle later. Four R beats reach m0 with m0_rid=2 and last on beat 4. m1_rvalid stays 0.
- **Simultaneous reads.** m0 and m1 arvalid in the same cycle → M0 is granted first and M1 after M0's rlast. A second simultaneous pair then grants M1 first (round-robin).
- **Single write.** M1 AW addr 0x40, len=0, wstrb=0x0F, data 0xDEADBEEF_CAFEF00D → s_awid MSB=1. Memory low 4 bytes are updated. m1_bvalid with bresp=0. m0_bvalid stays 0.
- **Concurrent read and write.** M0 read len=7 concurrent with M1 write len=1 → both complete. Each response is routed to its own master and no beats interleave wrongly.
- **Backpressure.** m0_rready=0 for 5 cycles mid-burst → s_rready=0. The beat is held stable, and no beat is lost or duplicated.
- **Reset mid-burst.** rst asserted during WDATA beat 2 of 4 → all valid/ready outputs are 0 the same cycle. After release, a new M1 write completes normally.
